// File: rtl/columns_collision_mux_if.sv
// ============================================================================
//  Module      : columns_collision_mux_if
//  Description : Pixel-stage bus between the sprite/columns drawing stages and
//                the collision mux. Master drives the requests and colours,
//                slave returns the displayed colour and collision reports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface columns_collision_mux_if #(
  parameter int COUNT_WIDTH = 10
) ();
  logic                   startOfFrame;
  logic                   playerDrawingRequest;
  logic [7:0]             playerRGB;
  logic                   bombDrawingRequest;
  logic [7:0]             bombRGB;
  logic                   columnsDrawingRequest;
  logic [7:0]             columnsRGB;
  logic [7:0]             backGroundRGB;
  logic [7:0]             RGBOut;
  logic                   playerColumnHit;
  logic                   bombColumnHit;
  logic [COUNT_WIDTH-1:0] overlapCount;

  modport master (
    output startOfFrame, playerDrawingRequest, playerRGB,
           bombDrawingRequest, bombRGB, columnsDrawingRequest, columnsRGB,
           backGroundRGB,
    input  RGBOut, playerColumnHit, bombColumnHit, overlapCount
  );

  modport slave (
    input  startOfFrame, playerDrawingRequest, playerRGB,
           bombDrawingRequest, bombRGB, columnsDrawingRequest, columnsRGB,
           backGroundRGB,
    output RGBOut, playerColumnHit, bombColumnHit, overlapCount
  );
endinterface

`default_nettype wire

// File: rtl/columns_collision_mux.sv
// ============================================================================
//  Module      : columns_collision_mux
//  Description : Layer-priority colour mux (player > bomb > columns >
//                background) with per-frame player/column and bomb/column
//                overlap detection, frame-boundary hit pulses and a player
//                hit cooldown.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module columns_collision_mux #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int COUNT_WIDTH     = 10
) (
  input  wire logic              clk,
  input  wire logic              reset,
  columns_collision_mux_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_RUN      = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] C_ACC_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [3:0]             C_CD_LOAD = 4'(COOLDOWN_FRAMES);

  state_t                 state_q, state_d;
  logic [3:0]             cd_cnt_q, cd_cnt_d;
  logic                   p_seen_q, p_seen_d;
  logic                   b_seen_q, b_seen_d;
  logic [COUNT_WIDTH-1:0] accum_q, accum_d;
  logic [7:0]             rgb_out_q, rgb_out_d;
  logic                   p_hit_q, p_hit_d;
  logic                   b_hit_q, b_hit_d;
  logic [COUNT_WIDTH-1:0] overlap_q, overlap_d;

  logic p_ov;
  logic b_ov;
  logic sof;

  assign p_ov = bus.playerDrawingRequest & bus.columnsDrawingRequest;
  assign b_ov = bus.bombDrawingRequest & bus.columnsDrawingRequest;
  assign sof  = bus.startOfFrame;

  // Layer priority colour selection.
  always_comb begin
    rgb_out_d = bus.backGroundRGB;
    if (bus.playerDrawingRequest)       rgb_out_d = bus.playerRGB;
    else if (bus.bombDrawingRequest)    rgb_out_d = bus.bombRGB;
    else if (bus.columnsDrawingRequest) rgb_out_d = bus.columnsRGB;
  end

  // Frame accumulators; the boundary cycle's pixel already belongs to the new frame.
  always_comb begin
    if (sof) begin
      p_seen_d = p_ov;
      b_seen_d = b_ov;
      accum_d  = p_ov ? COUNT_WIDTH'(1) : '0;
    end else begin
      p_seen_d = p_seen_q | p_ov;
      b_seen_d = b_seen_q | b_ov;
      accum_d  = (p_ov && accum_q != C_ACC_MAX) ? accum_q + COUNT_WIDTH'(1) : accum_q;
    end
  end

  // Frame-boundary reporting and player-hit cooldown sequencing.
  always_comb begin
    state_d   = state_q;
    cd_cnt_d  = cd_cnt_q;
    p_hit_d   = 1'b0;
    b_hit_d   = 1'b0;
    overlap_d = overlap_q;
    if (sof) begin
      case (state_q)
        ST_SYNC: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          p_hit_d   = p_seen_q;
          b_hit_d   = b_seen_q;
          overlap_d = accum_q;
          if ((COOLDOWN_FRAMES > 0) && p_seen_q) begin
            state_d  = ST_COOLDOWN;
            cd_cnt_d = C_CD_LOAD;
          end
        end
        ST_COOLDOWN: begin
          b_hit_d   = b_seen_q;
          overlap_d = accum_q;
          if (cd_cnt_q == 4'd1) begin
            state_d  = ST_RUN;
            cd_cnt_d = 4'd0;
          end else begin
            cd_cnt_d = cd_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d  = ST_SYNC;
          cd_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // All state registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      cd_cnt_q  <= 4'd0;
      p_seen_q  <= 1'b0;
      b_seen_q  <= 1'b0;
      accum_q   <= '0;
      rgb_out_q <= 8'd0;
      p_hit_q   <= 1'b0;
      b_hit_q   <= 1'b0;
      overlap_q <= '0;
    end else begin
      state_q   <= state_d;
      cd_cnt_q  <= cd_cnt_d;
      p_seen_q  <= p_seen_d;
      b_seen_q  <= b_seen_d;
      accum_q   <= accum_d;
      rgb_out_q <= rgb_out_d;
      p_hit_q   <= p_hit_d;
      b_hit_q   <= b_hit_d;
      overlap_q <= overlap_d;
    end
  end

  assign bus.RGBOut          = rgb_out_q;
  assign bus.playerColumnHit = p_hit_q;
  assign bus.bombColumnHit   = b_hit_q;
  assign bus.overlapCount    = overlap_q;

endmodule

`default_nettype wire

// File: tb/tb_columns_collision_mux.sv
// ============================================================================
//  Module      : tb_columns_collision_mux
//  Description : Directed self-checking bench for columns_collision_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_columns_collision_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  columns_collision_mux_if #(.COUNT_WIDTH(10)) bus ();

  columns_collision_mux #(
    .COOLDOWN_FRAMES(4),
    .COUNT_WIDTH    (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic b, input logic c, input logic s);
    bus.playerDrawingRequest  = p;
    bus.bombDrawingRequest    = b;
    bus.columnsDrawingRequest = c;
    bus.startOfFrame          = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_boundary(input string tag, input logic ph, input logic bh,
                                input logic [31:0] cnt);
    check({tag, "_phit"}, 32'(bus.playerColumnHit), 32'(ph));
    check({tag, "_bhit"}, 32'(bus.bombColumnHit), 32'(bh));
    check({tag, "_count"}, 32'(bus.overlapCount), cnt);
  endtask

  // Idle cycles with nothing drawn and no boundary.
  task automatic idle(input int n);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n cycles of player/column overlap inside a frame.
  task automatic p_overlap(input int n);
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Single empty boundary cycle; outputs of that boundary are visible afterwards.
  task automatic boundary();
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.playerRGB     = 8'h1C;
    bus.bombRGB       = 8'hE0;
    bus.columnsRGB    = 8'h03;
    bus.backGroundRGB = 8'h92;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_rgb", 32'(bus.RGBOut), 32'h00);
    check_boundary("rst", 1'b0, 1'b0, 0);

    // Priority mux (also overlap before the first boundary)
    reset = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("prio_all", 32'(bus.RGBOut), 32'h1C);
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("prio_bomb", 32'(bus.RGBOut), 32'hE0);
    set_req(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("prio_col", 32'(bus.RGBOut), 32'h03);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("prio_bg", 32'(bus.RGBOut), 32'h92);
    p_overlap(5);
    check_boundary("presof", 1'b0, 1'b0, 0);

    // First boundary leaves SYNC without reporting the pre-frame overlap
    boundary();
    check_boundary("first_sof", 1'b0, 1'b0, 0);

    // Single overlap of 37 cycles -> cooldown boundary 1
    idle(3);
    p_overlap(37);
    idle(4);
    boundary();
    check_boundary("single", 1'b1, 1'b0, 37);
    tick();
    check("single_pulse_width", 32'(bus.playerColumnHit), 32'd0);

    // Frames 2..6 all overlap; only boundary 6 reports the player hit.
    for (int f = 2; f <= 6; f++) begin
      idle(2);
      p_overlap(f * 3);
      if (f == 3) begin
        set_req(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
      end
      idle(2);
      boundary();
      check_boundary($sformatf("cool_f%0d", f), (f == 6), (f == 3), 32'(f * 3));
      tick();
      check($sformatf("cool_f%0d_bwidth", f), 32'(bus.bombColumnHit), 32'd0);
    end

    // Reset mid-frame with a cooldown in progress
    p_overlap(6);
    reset = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("midrst_rgb", 32'(bus.RGBOut), 32'h00);
    reset = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    boundary();
    check_boundary("midrst_sof", 1'b0, 1'b0, 0);
    p_overlap(3);
    idle(1);
    boundary();
    check_boundary("midrst_nocool", 1'b1, 1'b0, 3);

    // Overlap only on the boundary cycle, taken in SYNC
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_boundary("sync_edge_sof", 1'b0, 1'b0, 0);
    idle(3);
    boundary();
    check_boundary("sync_edge_rep", 1'b1, 1'b0, 1);

    // Overlap only on the boundary cycle, taken in RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    boundary();
    idle(2);
    set_req(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_boundary("run_edge_sof", 1'b0, 1'b0, 0);
    idle(3);
    boundary();
    check_boundary("run_edge_rep", 1'b1, 1'b0, 1);

    // Saturation of the overlap counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    boundary();
    p_overlap(1500);
    boundary();
    check_boundary("saturate", 1'b1, 1'b0, 1023);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
